// File: rtl/roll_sequencer_pkg.sv
// roll_pkg: shared states, widths and the tick-counter width check for the roll sequencer
package roll_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LATCH} state_t;
  localparam int VAL_W = 4;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_STEPS_PER_STAGE = 8;
  localparam int TOTAL_STEPS = DEF_NUM_STAGES * DEF_STEPS_PER_STAGE;
  function automatic bit cnt_fits(int base, int stages, int w);
    return $clog2((longint'(base) << (stages - 1)) + 64'd1) <= w;
  endfunction
endpackage

// File: rtl/roll_sequencer_if.sv
// roll_if: start/result bundle between debouncer, generator and the roll sequencer
interface roll_if;
  import roll_pkg::*;
  logic             i_start;
  logic [VAL_W-1:0] i_rand;
  logic             o_step;
  logic             o_busy;
  logic             o_done;
  logic [VAL_W-1:0] o_value;
  logic [VAL_W-1:0] o_prev;
  modport master (output i_start, i_rand, input o_step, o_busy, o_done, o_value, o_prev);
  modport slave  (input i_start, i_rand, output o_step, o_busy, o_done, o_value, o_prev);
endinterface

// File: rtl/roll_sequencer_step_timer.sv
// step_timer: tick counter with doubling interval; expire is registered so it lines up with tick == interval-1
module step_timer #(
  parameter int BASE_INTERVAL = 2500000,
  parameter int CNT_W = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic do_double,
  input  logic run,
  output logic expire
);
  logic [CNT_W-1:0] tick, interval, tick_n, interval_n;
  always_comb begin
    tick_n = (clear || expire || !run) ? '0 : tick + CNT_W'(1);
    interval_n = clear ? CNT_W'(BASE_INTERVAL) : do_double ? interval << 1 : interval;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      tick <= '0;
      interval <= CNT_W'(BASE_INTERVAL);
      expire <= 1'b0;
    end else begin
      tick <= tick_n;
      interval <= interval_n;
      expire <= run && (tick_n == interval_n - CNT_W'(1));
    end
endmodule

// File: rtl/roll_sequencer.sv
// roll_sequencer: dice-roll controller issuing slowing step pulses, then latching the result with one-deep history
module roll_sequencer
  import roll_pkg::*;
#(
  parameter int BASE_INTERVAL = 2500000,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int STEPS_PER_STAGE = DEF_STEPS_PER_STAGE,
  parameter int CNT_W = 26
) (
  input logic i_clk,
  input logic i_rst_n,
  roll_if.slave bus
);
  localparam int SW = (STEPS_PER_STAGE > 1) ? $clog2(STEPS_PER_STAGE) : 1;
  localparam int GW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS_PER_STAGE - 1);
  localparam logic [GW-1:0] LAST_STAGE = GW'(NUM_STAGES - 1);
  state_t state, state_n;
  logic [SW-1:0] step_cnt, step_n;
  logic [GW-1:0] stage, stage_n;
  logic clear, do_double, run, expire;
  if (!cnt_fits(BASE_INTERVAL, NUM_STAGES, CNT_W)) begin : g_width_chk
    $error("CNT_W cannot hold BASE_INTERVAL << (NUM_STAGES-1)");
  end
  step_timer #(.BASE_INTERVAL(BASE_INTERVAL), .CNT_W(CNT_W)) u_timer (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .clear(clear),
    .do_double(do_double),
    .run(run),
    .expire(expire)
  );
  // run tells the timer whether the next cycle is a RUN cycle, so its pulse is already registered
  always_comb begin
    state_n = state;
    step_n = step_cnt;
    stage_n = stage;
    clear = 1'b1;
    run = 1'b0;
    do_double = 1'b0;
    case (state)
      S_IDLE: begin
        step_n = '0;
        stage_n = '0;
        run = bus.i_start;
        state_n = bus.i_start ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        run = 1'b1;
        if (bus.i_start) begin
          step_n = '0;
          stage_n = '0;
        end else begin
          clear = 1'b0;
          if (expire) begin
            if (step_cnt != LAST_STEP) step_n = step_cnt + SW'(1);
            else if (stage != LAST_STAGE) begin
              step_n = '0;
              stage_n = stage + GW'(1);
              do_double = 1'b1;
            end else begin
              run = 1'b0;
              state_n = S_LATCH;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_IDLE;
      step_cnt <= '0;
      stage <= '0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_value <= '0;
      bus.o_prev <= '0;
    end else begin
      state <= state_n;
      step_cnt <= step_n;
      stage <= stage_n;
      bus.o_busy <= state_n != S_IDLE;
      bus.o_done <= state == S_LATCH;
      if (state == S_LATCH) begin
        bus.o_prev <= bus.o_value;
        bus.o_value <= bus.i_rand;
      end
    end
  assign bus.o_step = expire;
endmodule

// File: tb/tb_roll_sequencer.sv
// tb_roll_sequencer: directed table, corner sequences and random stimulus against a schedule-based model
module tb_roll_sequencer;
  import roll_pkg::*;
  localparam int BASE = 2, NS = 3, SPS = 2, CW = 8;
  localparam int LEN = BASE * SPS * ((1 << NS) - 1);
  typedef struct { int cyc; logic [2:0] flags; logic [3:0] value, prev; } vec_t;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  roll_if bus();
  roll_sequencer #(.BASE_INTERVAL(BASE), .NUM_STAGES(NS), .STEPS_PER_STAGE(SPS), .CNT_W(CW)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .bus(bus)
  );
  always #5 i_clk = ~i_clk;
  int errors = 0, checks = 0, cyc = 0;
  bit m_active = 1'b0;
  int m_t0 = 0;
  logic [3:0] m_val = '0, m_prev = '0, m_lat = '0;
  logic [10:0] trc [64];
  int steps_q[$], dones_q[$];
  vec_t tbl[$];

  function automatic logic [10:0] outs();
    return {bus.o_step, bus.o_busy, bus.o_done, bus.o_value, bus.o_prev};
  endfunction

  task automatic chk(string name, logic [10:0] act, logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // steps fall at cumulative sums of BASE<<stage, counted from the start cycle
  function automatic bit is_step(int d);
    int t = 0;
    for (int g = 0; g < NS; g++)
      for (int s = 0; s < SPS; s++) begin
        t += BASE << g;
        if (t == d) return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int first_step_after(int lim);
    foreach (steps_q[i]) if (steps_q[i] > lim) return steps_q[i];
    return -1;
  endfunction

  function automatic int first_done();
    return dones_q.size() > 0 ? dones_q[0] : -1;
  endfunction

  task automatic mreset();
    m_active = 1'b0;
    m_val = '0;
    m_prev = '0;
    m_lat = '0;
  endtask

  task automatic cycle_step(bit start, logic [3:0] r);
    int d = cyc - m_t0;
    logic [10:0] e;
    bit fin;
    bus.i_start = start;
    bus.i_rand = r;
    fin = m_active && d == LEN + 2;
    if (fin) begin
      m_prev = m_val;
      m_val = m_lat;
    end
    e = {m_active && is_step(d), m_active && d >= 1 && d <= LEN + 1, fin, m_val, m_prev};
    chk("model", outs(), e);
    if (m_active && d == LEN + 1) m_lat = r;
    if (fin) m_active = 1'b0;
    if (start && !(m_active && d == LEN + 1)) begin
      m_active = 1'b1;
      m_t0 = cyc;
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic seq(int n, int s2, logic [3:0] r);
    steps_q.delete();
    dones_q.delete();
    for (int k = 0; k < n; k++) begin
      trc[k] = outs();
      if (bus.o_step) steps_q.push_back(k);
      if (bus.o_done) dones_q.push_back(k);
      cycle_step(k == 0 || k == s2, r);
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_rand = 4'h0;
    #12 chk("reset", outs(), 11'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 3; k++) cycle_step(1'b0, 4'h0);
    tbl.push_back('{0, 3'b000, 4'h0, 4'h0});
    tbl.push_back('{1, 3'b010, 4'h0, 4'h0});
    tbl.push_back('{2, 3'b110, 4'h0, 4'h0});
    tbl.push_back('{3, 3'b010, 4'h0, 4'h0});
    tbl.push_back('{4, 3'b110, 4'h0, 4'h0});
    tbl.push_back('{6, 3'b010, 4'h0, 4'h0});
    tbl.push_back('{8, 3'b110, 4'h0, 4'h0});
    tbl.push_back('{12, 3'b110, 4'h0, 4'h0});
    tbl.push_back('{20, 3'b110, 4'h0, 4'h0});
    tbl.push_back('{27, 3'b010, 4'h0, 4'h0});
    tbl.push_back('{28, 3'b110, 4'h0, 4'h0});
    tbl.push_back('{29, 3'b010, 4'h0, 4'h0});
    tbl.push_back('{30, 3'b001, 4'h7, 4'h0});
    tbl.push_back('{31, 3'b000, 4'h7, 4'h0});
    seq(32, -1, 4'h7);
    foreach (tbl[i])
      chk($sformatf("full_c%0d", tbl[i].cyc), trc[tbl[i].cyc], {tbl[i].flags, tbl[i].value, tbl[i].prev});
    chk_int("full_nsteps", steps_q.size(), 6);
    chk_int("full_done_cyc", first_done(), 30);
    chk_int("full_ndone", dones_q.size(), 1);
    seq(32, -1, 4'hA);
    chk("hist", trc[31], {3'b000, 4'hA, 4'h7});
    chk_int("hist_done_cyc", first_done(), 30);
    chk_int("hist_ndone", dones_q.size(), 1);
    seq(42, 10, 4'h5);
    chk_int("restart_step", first_step_after(10), 12);
    chk_int("restart_done_cyc", first_done(), 40);
    chk_int("restart_ndone", dones_q.size(), 1);
    chk("restart_hold", trc[39] & 11'h0FF, {3'b000, 4'hA, 4'h7});
    chk("restart_result", trc[41] & 11'h0FF, {3'b000, 4'h5, 4'hA});
    seq(34, 28, 4'h3);
    chk_int("final_ndone", dones_q.size(), 0);
    chk_int("final_resume", first_step_after(28), 30);
    for (int k = 0; k < 30; k++) cycle_step(1'b0, 4'h3);
    seq(34, 29, 4'h9);
    chk_int("latch_done_cyc", first_done(), 30);
    chk_int("latch_ndone", dones_q.size(), 1);
    for (int k = 30; k < 34; k++) chk($sformatf("latch_idle_c%0d", k), trc[k] & 11'h600, 11'h0);
    chk("latch_result", trc[31], {3'b000, 4'h9, 4'h3});
    seq(15, -1, 4'h2);
    #3 i_rst_n = 1'b0;
    #1 chk("async_rst", outs(), 11'h0);
    mreset();
    @(posedge i_clk);
    #1;
    cyc++;
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cycle_step(1'b0, 4'h2);
    seq(32, -1, 4'h6);
    chk("post_rst", trc[31], {3'b000, 4'h6, 4'h0});
    for (int k = 0; k < 800; k++) cycle_step($urandom_range(0, 39) == 0, 4'($urandom));
    for (int k = 0; k < 40; k++) cycle_step(1'b0, 4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
